// File: rtl/addsub_nibble_sequencer.sv
// Multi-cycle controller for an external 4-bit add/sub slice: feeds a WORDS*4-bit
// add or subtract through the slice one nibble per cycle, LSB first, and returns sum plus flags.
module addsub_nibble_sequencer #(
   parameter int WORDS = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 op_valid,
   output logic                 op_ready,
   input  logic [4*WORDS-1:0]   op_a,
   input  logic [4*WORDS-1:0]   op_b,
   input  logic                 op_sub,
   output logic [3:0]           add_a,
   output logic [3:0]           add_b,
   output logic                 add_m,
   output logic                 add_cin,
   input  logic [3:0]           add_sum,
   input  logic                 add_cout,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [4*WORDS-1:0]   res_sum,
   output logic                 res_cout,
   output logic                 res_ovf,
   output logic                 res_zero,
   output logic                 res_neg
);

   localparam int W  = 4 * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] idx;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic          sub_reg;
   logic          carry_reg;
   logic [W-1:0]  sum_next;
   logic          beff;
   logic          in_run;

   assign in_run    = (state == S_RUN);
   assign op_ready  = rst_n && (state == S_IDLE);
   assign res_valid = (state == S_DONE);
   assign beff      = b_reg[W-1] ^ sub_reg;

   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_m   = 1'b0;
      add_cin = 1'b0;
      if (in_run) begin
         add_a   = a_reg[{idx, 2'b00} +: 4];
         add_b   = b_reg[{idx, 2'b00} +: 4];
         add_m   = sub_reg;
         add_cin = (idx == '0) ? sub_reg : carry_reg;
      end
   end

   // Full sum as it will look after this edge; the zero flag needs the final nibble included.
   always_comb begin
      sum_next = res_sum;
      sum_next[{idx, 2'b00} +: 4] = add_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         idx       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         sub_reg   <= 1'b0;
         carry_reg <= 1'b0;
         res_sum   <= '0;
         res_cout  <= 1'b0;
         res_ovf   <= 1'b0;
         res_zero  <= 1'b0;
         res_neg   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (op_valid) begin
                  a_reg   <= op_a;
                  b_reg   <= op_b;
                  sub_reg <= op_sub;
                  idx     <= '0;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               res_sum   <= sum_next;
               carry_reg <= add_cout;
               if (idx == LAST_IDX) begin
                  res_cout <= add_cout;
                  res_ovf  <= (a_reg[W-1] == beff) && (add_sum[3] != a_reg[W-1]);
                  res_zero <= (sum_next == '0);
                  res_neg  <= add_sum[3];
                  state    <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            S_DONE: begin
               if (res_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_nibble_sequencer.sv
// Scoreboard bench for addsub_nibble_sequencer (WORDS=2) with a behavioural 4-bit add/sub slice.
module tb_addsub_nibble_sequencer;

   localparam int WORDS = 2;
   localparam int W     = 4 * WORDS;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          op_valid = 1'b0;
   logic          op_ready;
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic          op_sub = 1'b0;
   logic [3:0]    add_a, add_b, add_sum;
   logic          add_m, add_cin, add_cout;
   logic          res_valid;
   logic          res_ready = 1'b1;
   logic [W-1:0]  res_sum;
   logic          res_cout, res_ovf, res_zero, res_neg;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cyc = 0;
   logic [11:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Slice: sum = a + (b ^ M) + c_in
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b ^ {4{add_m}}} + {4'b0000, add_cin};

   addsub_nibble_sequencer #(.WORDS(WORDS)) dut (
      .clk(clk), .rst_n(rst_n),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
      .add_a(add_a), .add_b(add_b), .add_m(add_m), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf),
      .res_zero(res_zero), .res_neg(res_neg)
   );

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endfunction

   // Monitor: {sum, cout, ovf, zero, neg} popped in order on each result handshake
   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result actual=%0h required=none", res_sum);
         end else begin
            chk("result", {res_sum, res_cout, res_ovf, res_zero, res_neg}, exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic [11:0] e, input bit push);
      int n = 0;
      while (!op_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!op_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout actual=%0b required=1", op_ready);
      end
      op_a = a; op_b = b; op_sub = sub; op_valid = 1'b1;
      if (push) exp_q.push_back(e);
      @(posedge clk); #1;
      op_valid = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      logic [W-1:0] ba [3];
      logic [W-1:0] bb [3];
      logic         bs [3];
      logic [11:0]  be [3];
      int           bacc [3];
      int           k;
      int           n;

      // Reset state
      #12;
      chk("reset_op_ready", op_ready, 0);
      chk("reset_res_valid", res_valid, 0);
      chk("reset_res", {res_sum, res_cout, res_ovf, res_zero, res_neg}, 0);
      chk("reset_add", {add_a, add_b, add_m, add_cin}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("idle_op_ready", op_ready, 1);

      send(8'h3C, 8'h15, 1'b0, {8'h51, 4'b0000}, 1'b1);
      drain();

      // Subtract with slice-input and latency checks
      send(8'h05, 8'h07, 1'b1, {8'hFE, 4'b0001}, 1'b1);
      chk("sub_n0_cin_m", {add_cin, add_m}, 2'b11);
      chk("sub_n0_ab", {add_a, add_b}, 8'h57);
      chk("run_op_ready", op_ready, 0);
      @(posedge clk); #1;
      chk("sub_n1_m", add_m, 1);
      chk("sub_n1_cin", add_cin, 0);
      chk("sub_n1_valid", res_valid, 0);
      @(posedge clk); #1;
      chk("sub_latency_valid", res_valid, 1);
      chk("done_add_zero", {add_a, add_b, add_m, add_cin}, 0);
      drain();

      send(8'h7F, 8'h01, 1'b0, {8'h80, 4'b0101}, 1'b1);
      drain();
      send(8'hFF, 8'h01, 1'b0, {8'h00, 4'b1010}, 1'b1);
      drain();

      // Result held under back-pressure
      res_ready = 1'b0;
      send(8'h80, 8'h80, 1'b1, {8'h00, 4'b1010}, 1'b1);
      n = 0;
      while (!res_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", res_valid, 1);
         chk("hold_res", {res_sum, res_cout, res_ovf, res_zero, res_neg}, {8'h00, 4'b1010});
         chk("hold_op_ready", op_ready, 0);
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_valid", res_valid, 0);
      chk("release_op_ready", op_ready, 1);
      drain();

      // Reset during RUN at idx=1 aborts
      send(8'h12, 8'h34, 1'b0, 12'h000, 1'b0);
      @(posedge clk); #1;
      chk("abort_pre_add_a", add_a, 4'h1);
      rst_n = 1'b0;
      #1;
      chk("abort_add", {add_a, add_b, add_m, add_cin}, 0);
      chk("abort_res", {res_sum, res_cout, res_ovf, res_zero, res_neg}, 0);
      chk("abort_valid_ready", {res_valid, op_ready}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("abort_op_ready", op_ready, 1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("abort_no_result", res_valid, 0);
      end
      send(8'h11, 8'h22, 1'b0, {8'h33, 4'b0000}, 1'b1);
      drain();

      // Back-to-back with op_valid held high
      ba[0] = 8'h01; bb[0] = 8'h02; bs[0] = 1'b0; be[0] = {8'h03, 4'b0000};
      ba[1] = 8'hA5; bb[1] = 8'h5A; bs[1] = 1'b1; be[1] = {8'h4B, 4'b1100};
      ba[2] = 8'h80; bb[2] = 8'h80; bs[2] = 1'b0; be[2] = {8'h00, 4'b1110};
      k = 0;
      op_a = ba[0]; op_b = bb[0]; op_sub = bs[0]; op_valid = 1'b1;
      n = 0;
      while (k < 3 && n < 100) begin
         if (op_ready) begin
            exp_q.push_back(be[k]);
            @(posedge clk); #1;
            bacc[k] = cyc;
            k++;
            if (k < 3) begin
               op_a = ba[k]; op_b = bb[k]; op_sub = bs[k];
            end
         end else begin
            @(posedge clk); #1;
         end
         n++;
      end
      op_valid = 1'b0;
      chk("b2b_accepted", k, 3);
      if (k == 3) begin
         chk("b2b_spacing1", bacc[1] - bacc[0], WORDS + 2);
         chk("b2b_spacing2", bacc[2] - bacc[1], WORDS + 2);
      end
      drain();

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d required=finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
